dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of each per-requester service counter.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid[1:0]  in  2  request valid; bit k belongs to requester k.
REQ-005 req_we[1:0]  in  2  1 = store word, 0 = load word, per requester.
REQ-006 req_addr0, req_addr1  in  32 each  byte address per requester.
REQ-007 req_wdata0, req_wdata1  in  32 each  store data per requester.
REQ-008 req_ready[1:0]  out  2  grant; handshake on requester k when req_valid[k] & req_ready[k] at posedge.
REQ-009 rsp_valid[1:0]  out  2  one-cycle response pulse to requester k.
REQ-010 rsp_rdata  out  32  load data; valid only with rsp_valid.
REQ-011 rsp_err  out  1  misaligned-access flag; valid only with rsp_valid.
REQ-012 dm_we  out  1  data-memory write enable.
REQ-013 dm_addr  out  32  data-memory byte address.
REQ-014 dm_wdata  out  32  data-memory write data.
REQ-015 dm_rdata  in  32  data-memory read data, combinational from dm_addr.
REQ-016 svc_cnt0, svc_cnt1  out  CNT_W each  completed-access count per requester.

Function
REQ-017 FSM SHALL have exactly two states, IDLE and ACCESS.
REQ-018 In IDLE, at most one req_ready bit SHALL be high: the bit of the valid requester with current priority; the non-priority requester is granted only when the priority requester is not valid.
REQ-019 In ACCESS, req_ready SHALL be 2'b00.
REQ-020 On handshake in IDLE: latch id, we, addr, wdata of the granted requester; next state ACCESS.
REQ-021 In IDLE with no valid request: remain IDLE; dm_we = 0.
REQ-022 In ACCESS: dm_addr = latched addr, dm_wdata = latched wdata, dm_we = latched we & (addr[1:0]==2'b00); next state IDLE unconditionally.
REQ-023 In IDLE: dm_addr and dm_wdata SHALL hold their last driven values; dm_we = 0.
REQ-024 At the ACCESS posedge: rsp_rdata <= dm_rdata for an aligned load and 0 otherwise; rsp_err <= (addr[1:0]!=0); rsp_valid[id] <= 1 for exactly one cycle.
REQ-025 Misaligned access (addr[1:0]!=0): no memory write; rsp_err = 1; rsp_rdata = 0.
REQ-026 Latency: handshake at edge t, ACCESS during cycle t+1, rsp_valid high during cycle t+2 (the next IDLE cycle, which may accept a new request).
REQ-027 Throughput: at most one access per two cycles.
REQ-028 Round-robin: the priority pointer is updated at the ACCESS posedge to the requester not just served.
REQ-029 With both requesters continuously valid, grants SHALL alternate 0,1,0,1,...
REQ-030 svc_cnt[id] SHALL increment by 1 at the ACCESS posedge (misaligned accesses included) and wrap from 2^CNT_W-1 to 0.
REQ-031 Requester inputs that change while not handshaken SHALL have no effect; latched values SHALL be immune to input changes during ACCESS.

Reset
REQ-032 While reset is high at a posedge: state <= IDLE, priority <= requester 0, rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0, svc_cnt0/1 <= 0, latched registers <= 0.
REQ-033 dm_we SHALL be 0 in any cycle with reset high, including reset asserted during ACCESS; that access is dropped with no response.
REQ-034 req_ready SHALL be 2'b00 in any cycle with reset high.

Verification
REQ-035 Single store: req0 we=1, addr=0x10, wdata=0xDEADBEEF -> dm_we=1, dm_addr=0x10 one cycle later; rsp_valid=2'b01 next cycle, rsp_err=0; svc_cnt0=1.
REQ-036 Load-back: req1 load addr=0x10 after REQ-035 -> rsp_valid=2'b10 two cycles after handshake with rsp_rdata=0xDEADBEEF.
REQ-037 Contention: both valid continuously from reset for 8 cycles -> grant order 0,1,0,1; svc_cnt0=2, svc_cnt1=2.
REQ-038 Misaligned: req0 store addr=0x13 -> dm_we never high; rsp_err=1, rsp_rdata=0, rsp_valid=2'b01; svc_cnt0 increments.
REQ-039 Reset mid-access: reset high during the ACCESS cycle of a store to 0x20 -> dm_we=0 in that cycle; no rsp_valid; all counters 0.
REQ-040 Counter wrap with CNT_W=2: 5 accesses by req0 -> svc_cnt0=1.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes one IDLE grant cycle and one ACCESS cycle, so a new access can start at most every second cycle.
module dm_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_we,
    input  logic [31:0]      req_addr0,
    input  logic [31:0]      req_addr1,
    input  logic [31:0]      req_wdata0,
    input  logic [31:0]      req_wdata1,
    output logic [1:0]       req_ready,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata,
    output logic [CNT_W-1:0] svc_cnt0,
    output logic [CNT_W-1:0] svc_cnt1
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  state;
    logic        prio;
    logic        lat_id;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  grant;
    logic        aligned;

    always_comb begin
        grant = '0;
        if (!reset && state == IDLE) begin
            if (prio == 1'b0) begin
                if (req_valid[0])      grant = 2'b01;
                else if (req_valid[1]) grant = 2'b10;
            end else begin
                if (req_valid[1])      grant = 2'b10;
                else if (req_valid[0]) grant = 2'b01;
            end
        end
    end

    assign req_ready = grant;
    assign aligned   = (lat_addr[1:0] == 2'b00);

    // The latched request is only replaced at the next handshake, so the
    // memory address/data naturally hold their last values through IDLE.
    assign dm_addr  = lat_addr;
    assign dm_wdata = lat_wdata;
    assign dm_we    = !reset && (state == ACCESS) && lat_we && aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            svc_cnt0  <= '0;
            svc_cnt1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= '0;
                    if (|grant) begin
                        lat_id    <= grant[1];
                        lat_we    <= grant[1] ? req_we[1]  : req_we[0];
                        lat_addr  <= grant[1] ? req_addr1  : req_addr0;
                        lat_wdata <= grant[1] ? req_wdata1 : req_wdata0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_valid <= lat_id ? 2'b10 : 2'b01;
                    rsp_rdata <= (!lat_we && aligned) ? dm_rdata : '0;
                    rsp_err   <= !aligned;
                    prio      <= !lat_id;
                    if (lat_id) svc_cnt1 <= svc_cnt1 + 1'b1;
                    else        svc_cnt0 <= svc_cnt0 + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
